// File: rtl/gpio_in.sv
// GPIO input block: synchronizes and debounces 32 pins, with rising-edge status, interrupt mask and CPU readback.
// Define GPIO_IN_DEBOUNCE_EN to compile in the per-bit debounce counters; otherwise deb follows the synchronizer.
module gpio_in #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] gpio_pins,
    input  logic [31:0] address_gpio,
    input  logic [31:0] dato_gpio,
    input  logic        we,
    input  logic        re,
    output logic [31:0] read_data,
    output logic        read_valid,
    output logic        irq
);

    localparam logic [31:0] ADDR_PIN  = 32'hABD0;
    localparam logic [31:0] ADDR_EDGE = 32'hABD4;
    localparam logic [31:0] ADDR_MASK = 32'hABD8;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_cfg
        $error("gpio_in: DEBOUNCE_CYCLES must be 1..15");
    end

    logic [31:0] s1_q, s2_q;
    logic [31:0] deb;
    logic [31:0] deb_prev_q;
    logic [31:0] edge_q, edge_d;
    logic [31:0] mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        irq_q, irq_d;
    logic [31:0] rmux;
    logic [31:0] clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= gpio_pins;
            s2_q <= s1_q;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam logic [3:0] LIMIT = 4'(DEBOUNCE_CYCLES - 1);

    logic [3:0]  cnt_q [32];
    logic [3:0]  cnt_d [32];
    logic [31:0] deb_q, deb_d;

    // A bit is accepted only after s2 has differed from deb for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == LIMIT) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= '0;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign deb = deb_q;
`else
    assign deb = s2_q;
`endif

    always_comb begin
        rmux = '0;
        unique case (address_gpio)
            ADDR_PIN:  rmux = deb;
            ADDR_EDGE: rmux = edge_q;
            ADDR_MASK: rmux = mask_q;
            default:   rmux = '0;
        endcase
    end

    // A new rising edge overrides a same-cycle write-1-to-clear.
    assign clr     = (we && address_gpio == ADDR_EDGE) ? dato_gpio : '0;
    assign edge_d  = (edge_q & ~clr) | (deb & ~deb_prev_q);
    assign mask_d  = (we && address_gpio == ADDR_MASK) ? dato_gpio : mask_q;
    assign irq_d   = |(edge_q & mask_q);
    assign rdata_d = re ? rmux : rdata_q;
    assign rvalid_d = re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_prev_q <= '0;
            edge_q     <= '0;
            mask_q     <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            deb_prev_q <= deb;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            irq_q      <= irq_d;
        end
    end

    assign read_data  = rdata_q;
    assign read_valid = rvalid_q;
    assign irq        = irq_q;

endmodule

// File: doc/gpio_in.md
GPIO_IN -- requirements
Module: gpio_in

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, range 1..15: consecutive stable synchronized cycles required before a pin change is accepted.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 gpio_pins  input  32  external asynchronous input pins.
REQ-005 address_gpio  input  32  CPU byte address.
REQ-006 dato_gpio  input  32  CPU write data.
REQ-007 we  input  1  CPU write strobe, one cycle per access.
REQ-008 re  input  1  CPU read strobe, one cycle per access.
REQ-009 read_data  output  32  registered read return.
REQ-010 read_valid  output  1  one-cycle pulse qualifying read_data.
REQ-011 irq  output  1  registered level interrupt.

Function
REQ-012 Register map: 32'hABD0 PIN (RO, debounced pin value); 32'hABD4 EDGE (rising-edge status, write-1-to-clear); 32'hABD8 MASK (RW, interrupt enable per bit).
REQ-013 Each pin bit shall pass through a 2-flop synchronizer (s1, s2) before any other use.
REQ-014 Debounce per bit: counter increments while s2 != deb, clears when equal; when the counter reaches DEBOUNCE_CYCLES-1 with s2 still != deb, deb loads s2 and the counter clears.
REQ-015 Latency: a pin change held stable appears in PIN exactly 2+DEBOUNCE_CYCLES clock edges after the first sampling edge.
REQ-016 Glitches shorter than DEBOUNCE_CYCLES synchronized cycles shall not change deb, EDGE or irq.
REQ-017 Edge detect: deb_prev <= deb each cycle; EDGE[i] sets on the edge after deb[i] rises (deb & ~deb_prev); falling edges do not set EDGE.
REQ-018 EDGE bits are sticky until cleared by a write to 32'hABD4 with the corresponding dato_gpio bit = 1; 0 bits leave status unchanged.
REQ-019 Same-cycle set and clear of one EDGE bit: set wins, bit reads 1.
REQ-020 MASK write: we=1 at 32'hABD8 loads dato_gpio on that edge; writes to PIN or unmapped addresses are ignored.
REQ-021 irq <= |(EDGE & MASK), registered; irq rises one cycle after the enabling EDGE/MASK state exists and falls one cycle after it is removed.
REQ-022 Read: re=1 -> read_data loaded with the addressed register and read_valid=1 on the next edge; read_valid is 0 in all other cycles.
REQ-023 Read of an unmapped address returns 32'd0 with read_valid=1.
REQ-024 Read of EDGE returns the value before any same-cycle write clear; reads have no side effects.
REQ-025 we and re both asserted in one cycle: both performed; read returns the pre-write value.
REQ-026 Accesses at 32'hABCD (output port) are not decoded here and return 0 if read.

Reset
REQ-027 rst_n=0 asynchronously clears s1, s2, deb, deb_prev, all debounce counters, EDGE, MASK, read_data, read_valid and irq to 0.
REQ-028 Reset asserted mid-debounce discards the pending count; after release, a pin held high is accepted as a new rising edge (EDGE sets) after full latency.
REQ-029 Deassertion of rst_n is followed by normal operation on the first rising clk edge.

Configuration
REQ-030 Macro GPIO_IN_DEBOUNCE_EN defined: debounce per REQ-014..016 compiled in.
REQ-031 Macro GPIO_IN_DEBOUNCE_EN undefined: no counters; deb = s2 directly; PIN latency 2 edges, EDGE sets on edge 3, irq on edge 4; DEBOUNCE_CYCLES ignored.

Verification
REQ-032 Reset, then gpio_pins=32'h0000_0005 held -> PIN reads 32'h5 after 6 edges (DEBOUNCE_CYCLES=4); EDGE reads 32'h5.
REQ-033 Pulse gpio_pins[3] high for 2 cycles -> PIN, EDGE, irq remain 0 (debounce on).
REQ-034 MASK=32'h1, rise on bit 0 -> EDGE[0]=1, irq=1 one cycle later; write 32'h1 to 32'hABD4 -> EDGE=0, irq=0 next cycle.
REQ-035 New rising edge on bit 1 in same cycle as W1C of bit 1 -> EDGE[1] reads 1.
REQ-036 Read 32'hABCC -> read_data=0, read_valid one-cycle pulse; read+write MASK same cycle -> old MASK returned.
REQ-037 Assert rst_n=0 mid-debounce with pin high, release -> all outputs 0, EDGE sets after full 3+DEBOUNCE_CYCLES edges.
